// File: rtl/hsb_avst_axis_shim.sv
// Avalon-ST sink to AXI4-Stream master with SOP/EOP repair, empty->tkeep, optional byte swap.
// Accept-to-tvalid latency 1 cycle; 2-entry skid buffer, av_snk_ready registered (free slot available).
module hsb_avst_axis_shim #(
  parameter int C_BYTE_SWAP          = 1,
  parameter int C_AV_EMPTY_WIDTH     = 3,
  parameter int C_AXIS_TUSER_WIDTH   = 1,
  parameter int C_M_AXIS_TDATA_WIDTH = 64,
  parameter int C_CNT_WIDTH          = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                av_snk_startofpacket,
  input  logic                                av_snk_endofpacket,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     av_snk_data,
  input  logic [C_AV_EMPTY_WIDTH-1:0]         av_snk_empty,
  input  logic                                av_snk_valid,
  output logic                                av_snk_ready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                                m_axis_tlast,
  output logic [C_AXIS_TUSER_WIDTH-1:0]       m_axis_tuser,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [C_CNT_WIDTH-1:0]              pkt_count,
  output logic [C_CNT_WIDTH-1:0]              err_orphan_count,
  output logic [C_CNT_WIDTH-1:0]              err_no_eop_count
);

  localparam int DW    = C_M_AXIS_TDATA_WIDTH;
  localparam int BYTES = DW / 8;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [BYTES-1:0] keep;
    logic             last;
    logic             sop;
  } beat_t;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t     state;
  beat_t      slot [2];
  beat_t      in_beat;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       acc;
  logic       push;
  logic       pop;
  logic       orphan;
  logic       no_eop;
  int         e_clamp;

  // Swap and keep generation on the incoming beat; empty only matters on EOP.
  always_comb begin
    e_clamp = BYTES - 1;
    if (int'(av_snk_empty) < BYTES - 1) e_clamp = int'(av_snk_empty);
    in_beat      = '0;
    in_beat.last = av_snk_endofpacket;
    in_beat.sop  = av_snk_startofpacket;
    for (int i = 0; i < BYTES; i++) begin
      if (C_BYTE_SWAP != 0) in_beat.data[8*i +: 8] = av_snk_data[8*(BYTES-1-i) +: 8];
      else                  in_beat.data[8*i +: 8] = av_snk_data[8*i +: 8];
      in_beat.keep[i] = !av_snk_endofpacket || (i < BYTES - e_clamp);
    end
  end

  assign acc        = av_snk_valid && av_snk_ready;
  assign orphan     = acc && !av_snk_startofpacket && (state == IDLE);
  assign no_eop     = acc && av_snk_startofpacket && (state == IN_PKT);
  assign push       = acc && (av_snk_startofpacket || (state == IN_PKT));
  assign pop        = (count != 2'd0) && m_axis_tready;
  assign count_next = count + 2'(push) - 2'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      count            <= 2'd0;
      wr_ptr           <= 1'b0;
      rd_ptr           <= 1'b0;
      av_snk_ready     <= 1'b0;
      pkt_count        <= '0;
      err_orphan_count <= '0;
      err_no_eop_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
        state  <= av_snk_endofpacket ? IDLE : IN_PKT;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count        <= count_next;
      av_snk_ready <= (count_next != 2'd2);
      if (orphan && (err_orphan_count != '1)) err_orphan_count <= err_orphan_count + 1'b1;
      if (no_eop && (err_no_eop_count != '1)) err_no_eop_count <= err_no_eop_count + 1'b1;
      if (pop && slot[rd_ptr].last && (pkt_count != '1)) pkt_count <= pkt_count + 1'b1;
    end
  end

  // Payload storage needs no reset: tvalid masks stale entries.
  always_ff @(posedge clk) begin
    if (push) slot[wr_ptr] <= in_beat;
  end

  assign m_axis_tvalid = (count != 2'd0);
  assign m_axis_tdata  = slot[rd_ptr].data;
  assign m_axis_tkeep  = slot[rd_ptr].keep;
  assign m_axis_tlast  = slot[rd_ptr].last;

  always_comb begin
    m_axis_tuser    = '0;
    m_axis_tuser[0] = slot[rd_ptr].sop;
  end

endmodule

// File: tb/tb_hsb_avst_axis_shim.sv
// Randomized and directed bench for hsb_avst_axis_shim against a queue-based framing model.
module tb_hsb_avst_axis_shim;

  localparam int DW = 64;
  localparam int EW = 4;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          av_sop = 1'b0;
  logic          av_eop = 1'b0;
  logic [DW-1:0] av_data = '0;
  logic [EW-1:0] av_empty = '0;
  logic          av_valid = 1'b0;
  logic          av_snk_ready;
  logic [DW-1:0] m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tlast;
  logic [0:0]    m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] err_orphan_count;
  logic [CW-1:0] err_no_eop_count;

  hsb_avst_axis_shim #(
    .C_BYTE_SWAP(1), .C_AV_EMPTY_WIDTH(EW), .C_AXIS_TUSER_WIDTH(1),
    .C_M_AXIS_TDATA_WIDTH(DW), .C_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .av_snk_startofpacket(av_sop), .av_snk_endofpacket(av_eop),
    .av_snk_data(av_data), .av_snk_empty(av_empty),
    .av_snk_valid(av_valid), .av_snk_ready(av_snk_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .pkt_count(pkt_count), .err_orphan_count(err_orphan_count),
    .err_no_eop_count(err_no_eop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  beat_t q[$];
  beat_t got[$];
  int    checks = 0;
  int    failures = 0;
  bit    in_pkt = 0;
  bit    rst_pend = 0;
  int    m_pkt = 0, m_orph = 0, m_noeop = 0;
  int    tr_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= int'(CMAX)) ? int'(CMAX) : v + 1;
  endfunction

  function automatic beat_t model_beat(input logic sop, eop, input logic [63:0] d, input logic [EW-1:0] e);
    beat_t b;
    int    ec;
    for (int k = 0; k < 8; k++) b.data[8*k +: 8] = d[8*(7-k) +: 8];
    ec     = (int'(e) > 7) ? 7 : int'(e);
    b.keep = eop ? (8'hFF >> ec) : 8'hFF;
    b.last = eop;
    b.user = sop;
    return b;
  endfunction

  // Compare process: outputs are checked at the falling edge, then the model consumes this cycle's handshakes.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      in_pkt = 0; m_pkt = 0; m_orph = 0; m_noeop = 0;
      rst_pend = 1;
    end else begin
      if (rst_pend) begin
        chk("ready_in_reset_cycle", av_snk_ready, 0);
        rst_pend = 0;
      end else begin
        chk("ready_vs_occupancy", av_snk_ready, (q.size() < 2));
      end
      chk("tvalid", m_axis_tvalid, (q.size() != 0));
      if (m_axis_tvalid && q.size() != 0) begin
        chk("tdata", m_axis_tdata, q[0].data);
        chk("tkeep", m_axis_tkeep, q[0].keep);
        chk("tlast", m_axis_tlast, q[0].last);
        chk("tuser", m_axis_tuser, q[0].user);
      end
      chk("pkt_count", pkt_count, m_pkt);
      chk("orphan_count", err_orphan_count, m_orph);
      chk("no_eop_count", err_no_eop_count, m_noeop);
      if (m_axis_tvalid && m_axis_tready && q.size() != 0) begin
        got.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser[0]});
        if (q[0].last) m_pkt = sat(m_pkt);
        void'(q.pop_front());
      end
      if (av_valid && av_snk_ready) begin
        if (!av_sop && !in_pkt) m_orph = sat(m_orph);
        else begin
          if (av_sop && in_pkt) m_noeop = sat(m_noeop);
          q.push_back(model_beat(av_sop, av_eop, av_data, av_empty));
          in_pkt = !av_eop;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (tr_mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = ~m_axis_tready;
      2: m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; av_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic send_beat(input logic sop, eop, input logic [63:0] d, input logic [EW-1:0] e);
    bit ok = 0;
    av_valid = 1'b1; av_sop = sop; av_eop = eop; av_data = d; av_empty = e;
    for (int k = 0; k < 100 && !ok; k++) begin
      ok = av_snk_ready;
      tick();
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=stalled required=accepted t=%0t", $time);
    end
  endtask

  task automatic idle(input int n);
    av_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int k = 0;
    av_valid = 1'b0;
    tr_mode = 0;
    while (q.size() != 0 && k < 200) begin tick(); k++; end
    tick(); tick();
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tr_mode = 0;
    do_reset();
    tick();
    chk("ready_after_reset", av_snk_ready, 1);
    chk("tvalid_after_reset", m_axis_tvalid, 0);

    // 3-beat packet with literal expectations.
    got.delete();
    send_beat(1, 0, 64'h0102030405060708, 0);
    send_beat(0, 0, 64'h1112131415161718, 0);
    send_beat(0, 1, 64'h2122232425262728, 3);
    drain();
    chk("p3_beats", got.size(), 3);
    chk("p3_data0", got[0].data, 64'h0807060504030201);
    chk("p3_user", {got[0].user, got[1].user, got[2].user}, 3'b100);
    chk("p3_last", {got[0].last, got[1].last, got[2].last}, 3'b001);
    chk("p3_keep", {got[0].keep, got[1].keep, got[2].keep}, 24'hFFFF1F);
    chk("p3_pkt", pkt_count, 1);

    // 16-beat stream with tready toggling.
    got.delete();
    tr_mode = 1;
    for (int i = 0; i < 16; i++)
      send_beat(i == 0, i == 15, {$urandom, $urandom}, 4'(i));
    drain();
    chk("stream_beats", got.size(), 16);
    chk("stream_pkt", pkt_count, 2);

    // Orphans after reset.
    do_reset();
    got.delete();
    send_beat(0, 0, 64'hAA, 0);
    send_beat(0, 1, 64'hBB, 0);
    drain();
    chk("orphan_no_output", got.size(), 0);
    chk("orphan_count", err_orphan_count, 2);
    chk("orphan_ready", av_snk_ready, 1);

    // SOP, -, SOP, EOP.
    do_reset();
    got.delete();
    send_beat(1, 0, 64'h1, 0);
    send_beat(0, 0, 64'h2, 0);
    send_beat(1, 0, 64'h3, 0);
    send_beat(0, 1, 64'h4, 0);
    drain();
    chk("noeop_beats", got.size(), 4);
    chk("noeop_user", {got[0].user, got[1].user, got[2].user, got[3].user}, 4'b1010);
    chk("noeop_last", {got[0].last, got[1].last, got[2].last, got[3].last}, 4'b0001);
    chk("noeop_count", err_no_eop_count, 1);
    chk("noeop_pkt", pkt_count, 1);

    // Single-beat packets: empty=7, clamped empty=9, empty=0.
    got.delete();
    send_beat(1, 1, 64'h55, 7);
    send_beat(1, 1, 64'h66, 9);
    send_beat(1, 1, 64'h77, 0);
    drain();
    chk("single_keep7", got[0].keep, 8'h01);
    chk("single_keep9", got[1].keep, 8'h01);
    chk("single_keep0", got[2].keep, 8'hFF);
    chk("single_user_last", {got[0].user, got[0].last}, 2'b11);

    // Saturation of the orphan counter.
    for (int i = 0; i < int'(CMAX) + 3; i++) send_beat(0, 0, 64'(i), 0);
    drain();
    chk("orphan_saturate", err_orphan_count, CMAX);

    // Reset with a held packet.
    tr_mode = 3;
    send_beat(1, 0, 64'h9, 0);
    send_beat(0, 0, 64'hA, 0);
    av_valid = 1'b0;
    tick();
    chk("held_before_reset", m_axis_tvalid, 1);
    reset = 1'b1;
    tick();
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_cnt", {pkt_count, err_orphan_count, err_no_eop_count}, 0);
    tick();
    reset = 1'b0;
    tr_mode = 0;
    tick();

    // Randomized framing, gaps and backpressure.
    tr_mode = 2;
    for (int n = 0; n < 400; n++) begin
      send_beat(($urandom % 4) == 0, ($urandom % 3) == 0, {$urandom, $urandom}, 4'($urandom));
      if (($urandom % 4) == 0) idle(1 + ($urandom % 2));
    end
    drain();
    chk("random_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
